// File: rtl/simo_fifo_if.sv
// simo_fifo_if: handshake/data bundle for simo_fifo.
//   slave  modport: used by the FIFO (takes clear/write/pop, drives lanes and flags)
//   master modport: used by whoever feeds and drains the FIFO
// Signals:
//   i_clear     synchronous flush
//   i_write_en  push i_data this cycle
//   i_data      element to push
//   i_pop_en    pop up to DATA_LENGTH elements
//   o_data      popped lanes, lane 0 = oldest
//   o_valid     per-lane qualifier, bit 0 = lane 0
//   o_empty     FIFO holds no elements
//   o_full      FIFO holds DEPTH elements
//   o_overflow  sticky dropped-write flag
interface simo_fifo_if #(
    parameter int DATA_WIDTH  = 8,
    parameter int DATA_LENGTH = 9
);
    logic                                    i_clear;
    logic                                    i_write_en;
    logic [DATA_WIDTH-1:0]                   i_data;
    logic                                    i_pop_en;
    logic [0:DATA_LENGTH-1][DATA_WIDTH-1:0]  o_data;
    logic [DATA_LENGTH-1:0]                  o_valid;
    logic                                    o_empty;
    logic                                    o_full;
    logic                                    o_overflow;

    modport slave (
        input  i_clear, i_write_en, i_data, i_pop_en,
        output o_data, o_valid, o_empty, o_full, o_overflow
    );

    modport master (
        output i_clear, i_write_en, i_data, i_pop_en,
        input  o_data, o_valid, o_empty, o_full, o_overflow
    );
endinterface

// File: rtl/simo_fifo.sv
// simo_fifo: single-input, multiple-output FIFO.
//   Accepts one DATA_WIDTH element per cycle and, on pop, presents up to
//   DATA_LENGTH of the oldest elements in parallel one cycle later with a
//   contiguous-from-LSB valid mask. Used to regroup a serial byte stream into
//   operand windows (e.g. 3x3 kernels) for the PE array.
// Ports:
//   i_clk   clock, rising edge
//   i_nrst  asynchronous active-low reset
//   bus     simo_fifo_if.slave (clear/write/pop in, lanes and flags out)
// Build option:
//   SIMO_FIFO_OVERFLOW_EN  when defined, o_overflow is a sticky flag set by a
//                          write attempted while full; otherwise tied to 0.
module simo_fifo #(
    parameter int DEPTH       = 32,
    parameter int DATA_WIDTH  = 8,
    parameter int DATA_LENGTH = 9,
    parameter int ADDR_WIDTH  = $clog2(DEPTH)
) (
    input  logic        i_clk,
    input  logic        i_nrst,
    simo_fifo_if.slave  bus
);
    localparam int CNT_W = ADDR_WIDTH + 1;

    logic [DATA_WIDTH-1:0]                   mem [DEPTH];
    logic [ADDR_WIDTH-1:0]                   wr_ptr;
    logic [ADDR_WIDTH-1:0]                   rd_ptr;
    logic [CNT_W-1:0]                        count;
    logic [0:DATA_LENGTH-1][DATA_WIDTH-1:0]  data_q;
    logic [DATA_LENGTH-1:0]                  valid_q;

    logic                                    full;
    logic                                    empty;
    logic                                    wr_ok;
    logic                                    pop_ok;
    logic [CNT_W-1:0]                        n_lanes;
    logic [CNT_W-1:0]                        n_taken;
    logic [0:DATA_LENGTH-1][DATA_WIDTH-1:0]  pop_data;
    logic [DATA_LENGTH-1:0]                  pop_valid;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    // Both decisions use the pre-edge count, so a pop never frees room for a
    // same-cycle write and never includes the element being written.
    assign wr_ok   = bus.i_write_en && !full;
    assign pop_ok  = bus.i_pop_en && !empty;
    assign n_lanes = (count > CNT_W'(DATA_LENGTH)) ? CNT_W'(DATA_LENGTH) : count;
    assign n_taken = pop_ok ? n_lanes : '0;

    // Lane k reads entry rd_ptr+k; the ADDR_WIDTH-bit sum wraps DEPTH-1 -> 0.
    always_comb begin
        pop_data  = '0;
        pop_valid = '0;
        for (int k = 0; k < DATA_LENGTH; k++) begin
            if (CNT_W'(k) < n_lanes) begin
                pop_data[k]  = mem[rd_ptr + ADDR_WIDTH'(k)];
                pop_valid[k] = 1'b1;
            end
        end
    end

    // Storage is deliberately not reset.
    always_ff @(posedge i_clk) begin
        if (!bus.i_clear && wr_ok) begin
            mem[wr_ptr] <= bus.i_data;
        end
    end

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            data_q  <= '0;
            valid_q <= '0;
        end else if (bus.i_clear) begin
            // o_data intentionally holds across a flush.
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            valid_q <= '0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
            end
            if (pop_ok) begin
                rd_ptr  <= rd_ptr + n_lanes[ADDR_WIDTH-1:0];
                data_q  <= pop_data;
                valid_q <= pop_valid;
            end else begin
                valid_q <= '0;
            end
            count <= count + CNT_W'(wr_ok) - n_taken;
        end
    end

`ifdef SIMO_FIFO_OVERFLOW_EN
    logic overflow_q;

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            overflow_q <= 1'b0;
        end else if (bus.i_clear) begin
            overflow_q <= 1'b0;
        end else if (bus.i_write_en && full) begin
            overflow_q <= 1'b1;
        end
    end

    assign bus.o_overflow = overflow_q;
`else
    assign bus.o_overflow = 1'b0;
`endif

    assign bus.o_data  = data_q;
    assign bus.o_valid = valid_q;
    assign bus.o_empty = empty;
    assign bus.o_full  = full;
endmodule

// File: tb/tb_simo_fifo.sv
// tb_simo_fifo: directed testbench for simo_fifo (DEPTH=32, 8-bit, 9 lanes).
module tb_simo_fifo;
    localparam int DW = 8;
    localparam int DL = 9;

`ifdef SIMO_FIFO_OVERFLOW_EN
    localparam logic OVF_EXP = 1'b1;
`else
    localparam logic OVF_EXP = 1'b0;
`endif

    logic clk;
    logic nrst;
    int   checks;
    int   errors;
    logic [DW-1:0] exp_lane [DL];

    simo_fifo_if #(.DATA_WIDTH(DW), .DATA_LENGTH(DL)) bus ();

    simo_fifo #(.DEPTH(32), .DATA_WIDTH(DW), .DATA_LENGTH(DL)) dut (
        .i_clk  (clk),
        .i_nrst (nrst),
        .bus    (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [DW-1:0] d);
        bus.i_write_en = 1'b1;
        bus.i_data     = d;
        step();
        bus.i_write_en = 1'b0;
    endtask

    task automatic pop();
        bus.i_pop_en = 1'b1;
        step();
        bus.i_pop_en = 1'b0;
    endtask

    task automatic clear();
        bus.i_clear = 1'b1;
        step();
        bus.i_clear = 1'b0;
    endtask

    task automatic test_reset();
        nrst = 1'b0;
        bus.i_clear = 1'b0; bus.i_write_en = 1'b0; bus.i_pop_en = 1'b0; bus.i_data = '0;
        step(); step();
        checks++;
        if (bus.o_empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b expected 1", bus.o_empty); end
        checks++;
        if (bus.o_full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b expected 0", bus.o_full); end
        checks++;
        if (bus.o_valid !== 9'h000) begin errors++; $display("FAIL reset_valid: got %h expected 000", bus.o_valid); end
        checks++;
        if (bus.o_data !== '0) begin errors++; $display("FAIL reset_data: got %h expected 0", bus.o_data); end
        checks++;
        if (bus.o_overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b expected 0", bus.o_overflow); end
        nrst = 1'b1;
        step();
    endtask

    task automatic test_partial_pop();
        for (int i = 0; i < 5; i++) push(8'h11 + 8'(i));
        pop();
        exp_lane = '{8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h00, 8'h00, 8'h00, 8'h00};
        checks++;
        if (bus.o_valid !== 9'b000011111) begin errors++; $display("FAIL partial_valid: got %b expected 000011111", bus.o_valid); end
        for (int k = 0; k < DL; k++) begin
            checks++;
            if (bus.o_data[k] !== exp_lane[k]) begin errors++; $display("FAIL partial_lane%0d: got %h expected %h", k, bus.o_data[k], exp_lane[k]); end
        end
        checks++;
        if (bus.o_empty !== 1'b1) begin errors++; $display("FAIL partial_empty: got %b expected 1", bus.o_empty); end
    endtask

    task automatic test_full_pop();
        for (int i = 0; i < 12; i++) push(8'(i));
        pop();
        checks++;
        if (bus.o_valid !== 9'h1FF) begin errors++; $display("FAIL two_pop1_valid: got %h expected 1ff", bus.o_valid); end
        for (int k = 0; k < DL; k++) begin
            checks++;
            if (bus.o_data[k] !== 8'(k)) begin errors++; $display("FAIL two_pop1_lane%0d: got %h expected %h", k, bus.o_data[k], 8'(k)); end
        end
        pop();
        exp_lane = '{8'h09, 8'h0A, 8'h0B, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        checks++;
        if (bus.o_valid !== 9'b000000111) begin errors++; $display("FAIL two_pop2_valid: got %b expected 000000111", bus.o_valid); end
        for (int k = 0; k < DL; k++) begin
            checks++;
            if (bus.o_data[k] !== exp_lane[k]) begin errors++; $display("FAIL two_pop2_lane%0d: got %h expected %h", k, bus.o_data[k], exp_lane[k]); end
        end
        step();
        checks++;
        if (bus.o_valid !== 9'h000) begin errors++; $display("FAIL two_pop_idle_valid: got %h expected 000", bus.o_valid); end
        checks++;
        if (bus.o_data[0] !== 8'h09) begin errors++; $display("FAIL two_pop_hold: got %h expected 09", bus.o_data[0]); end
        pop();
        checks++;
        if (bus.o_valid !== 9'h000) begin errors++; $display("FAIL pop_empty_valid: got %h expected 000", bus.o_valid); end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 32; i++) begin
            checks++;
            if (bus.o_full !== 1'b0) begin errors++; $display("FAIL ovf_not_full_%0d: got %b expected 0", i, bus.o_full); end
            push(8'(i));
        end
        checks++;
        if (bus.o_full !== 1'b1) begin errors++; $display("FAIL ovf_full: got %b expected 1", bus.o_full); end
        push(8'h20);
        checks++;
        if (bus.o_overflow !== OVF_EXP) begin errors++; $display("FAIL ovf_flag: got %b expected %b", bus.o_overflow, OVF_EXP); end
        for (int p = 0; p < 4; p++) begin
            pop();
            checks++;
            if (bus.o_valid !== ((p == 3) ? 9'h01F : 9'h1FF)) begin
                errors++; $display("FAIL ovf_pop%0d_valid: got %h expected %h", p, bus.o_valid, (p == 3) ? 9'h01F : 9'h1FF);
            end
            for (int k = 0; k < DL; k++) begin
                logic [DW-1:0] e;
                e = (p * 9 + k < 32) ? 8'(p * 9 + k) : 8'h00;
                checks++;
                if (bus.o_data[k] !== e) begin errors++; $display("FAIL ovf_pop%0d_lane%0d: got %h expected %h", p, k, bus.o_data[k], e); end
            end
        end
        checks++;
        if (bus.o_empty !== 1'b1) begin errors++; $display("FAIL ovf_drained_empty: got %b expected 1", bus.o_empty); end
        checks++;
        if (bus.o_overflow !== OVF_EXP) begin errors++; $display("FAIL ovf_sticky: got %b expected %b", bus.o_overflow, OVF_EXP); end
        clear();
        checks++;
        if (bus.o_overflow !== 1'b0) begin errors++; $display("FAIL ovf_cleared: got %b expected 0", bus.o_overflow); end
    endtask

    task automatic test_wrap();
        clear();
        for (int i = 0; i < 30; i++) push(8'(i));
        pop(); pop(); pop();
        for (int i = 0; i < 10; i++) push(8'hA0 + 8'(i));
        pop();
        exp_lane = '{8'd27, 8'd28, 8'd29, 8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5};
        checks++;
        if (bus.o_valid !== 9'h1FF) begin errors++; $display("FAIL wrap_valid: got %h expected 1ff", bus.o_valid); end
        for (int k = 0; k < DL; k++) begin
            checks++;
            if (bus.o_data[k] !== exp_lane[k]) begin errors++; $display("FAIL wrap_lane%0d: got %h expected %h", k, bus.o_data[k], exp_lane[k]); end
        end
        pop();
        exp_lane = '{8'hA6, 8'hA7, 8'hA8, 8'hA9, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        checks++;
        if (bus.o_valid !== 9'h00F) begin errors++; $display("FAIL wrap_tail_valid: got %h expected 00f", bus.o_valid); end
        for (int k = 0; k < DL; k++) begin
            checks++;
            if (bus.o_data[k] !== exp_lane[k]) begin errors++; $display("FAIL wrap_tail_lane%0d: got %h expected %h", k, bus.o_data[k], exp_lane[k]); end
        end
    endtask

    task automatic test_back_to_back();
        clear();
        push(8'h55);
        push(8'h66);
        bus.i_write_en = 1'b1;
        bus.i_data     = 8'h77;
        bus.i_pop_en   = 1'b1;
        step();
        bus.i_write_en = 1'b0;
        bus.i_pop_en   = 1'b0;
        exp_lane = '{8'h55, 8'h66, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        checks++;
        if (bus.o_valid !== 9'b000000011) begin errors++; $display("FAIL wrpop_valid: got %b expected 000000011", bus.o_valid); end
        for (int k = 0; k < DL; k++) begin
            checks++;
            if (bus.o_data[k] !== exp_lane[k]) begin errors++; $display("FAIL wrpop_lane%0d: got %h expected %h", k, bus.o_data[k], exp_lane[k]); end
        end
        checks++;
        if (bus.o_empty !== 1'b0) begin errors++; $display("FAIL wrpop_not_empty: got %b expected 0", bus.o_empty); end
        pop();
        checks++;
        if (bus.o_valid !== 9'b000000001) begin errors++; $display("FAIL wrpop_next_valid: got %b expected 000000001", bus.o_valid); end
        checks++;
        if (bus.o_data[0] !== 8'h77) begin errors++; $display("FAIL wrpop_next_lane0: got %h expected 77", bus.o_data[0]); end
        checks++;
        if (bus.o_empty !== 1'b1) begin errors++; $display("FAIL wrpop_next_empty: got %b expected 1", bus.o_empty); end
    endtask

    task automatic test_clear_reset();
        for (int i = 0; i < 20; i++) push(8'h40 + 8'(i));
        bus.i_clear  = 1'b1;
        bus.i_pop_en = 1'b1;
        step();
        bus.i_clear  = 1'b0;
        bus.i_pop_en = 1'b0;
        checks++;
        if (bus.o_valid !== 9'h000) begin errors++; $display("FAIL clear_pop_valid: got %h expected 000", bus.o_valid); end
        checks++;
        if (bus.o_empty !== 1'b1) begin errors++; $display("FAIL clear_empty: got %b expected 1", bus.o_empty); end
        checks++;
        if (bus.o_data[0] !== 8'h77) begin errors++; $display("FAIL clear_data_hold: got %h expected 77", bus.o_data[0]); end
        push(8'hC1); push(8'hC2); push(8'hC3);
        pop();
        checks++;
        if (bus.o_valid !== 9'b000000111) begin errors++; $display("FAIL prerst_valid: got %b expected 000000111", bus.o_valid); end
        push(8'hC4);
        bus.i_write_en = 1'b1;
        bus.i_data     = 8'hC5;
        #2;
        nrst = 1'b0;
        #1;
        checks++;
        if (bus.o_empty !== 1'b1) begin errors++; $display("FAIL midrst_empty: got %b expected 1", bus.o_empty); end
        checks++;
        if (bus.o_valid !== 9'h000) begin errors++; $display("FAIL midrst_valid: got %h expected 000", bus.o_valid); end
        checks++;
        if (bus.o_data !== '0) begin errors++; $display("FAIL midrst_data: got %h expected 0", bus.o_data); end
        checks++;
        if (bus.o_full !== 1'b0 || bus.o_overflow !== 1'b0) begin
            errors++; $display("FAIL midrst_flags: got full=%b ovf=%b expected 0/0", bus.o_full, bus.o_overflow);
        end
        bus.i_write_en = 1'b0;
        step();
        nrst = 1'b1;
        step();
        pop();
        checks++;
        if (bus.o_valid !== 9'h000) begin errors++; $display("FAIL postrst_pop_valid: got %h expected 000", bus.o_valid); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        nrst   = 1'b0;
        test_reset();
        test_partial_pop();
        test_full_pop();
        test_overflow();
        test_wrap();
        test_back_to_back();
        test_clear_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
